bcd_scan_display: RTL and testbench

//  Parametrised successor to the 8-bit switch-to-7-segment path. Takes a DATA_W-bit value on a load strobe.

---
 rtl/bcd_scan_display_pkg.sv | 28 ++
 rtl/bcd_scan_display_if.sv | 24 ++
 rtl/bcd_scan_display_conv.sv | 59 +++++
 rtl/bcd_scan_display.sv | 133 +++++++++++++
 tb/tb_bcd_scan_display.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_scan_display_pkg.sv
// rtl/bcd_scan_display_pkg.sv - segment constants, glyph codes and BCD sizing helper
package bcd_scan_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_DIGIT [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef enum logic [3:0] {
    G_DIG0, G_DIG1, G_DIG2, G_DIG3, G_DIG4,
    G_DIG5, G_DIG6, G_DIG7, G_DIG8, G_DIG9,
    G_BLANK, G_MINUS
  } glyph_e;

  function automatic int nbcd(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

  function automatic logic [6:0] seg_of(input glyph_e g);
    case (g)
      G_BLANK: return SEG_BLANK;
      G_MINUS: return SEG_MINUS;
      default: return (g <= G_DIG9) ? SEG_DIGIT[g] : SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// rtl/bcd_scan_display_if.sv - value load handshake and display pin bundle
interface bcd_scan_display_if #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
);
  logic [DATA_W-1:0] value_in;
  logic              signed_mode;
  logic              load;
  logic              busy;
  logic              ovf;
  logic [DIGITS-1:0] anode_ON;
  logic [6:0]        catodo_ON;
  logic              dp;

  modport master (
    output value_in, signed_mode, load,
    input  busy, ovf, anode_ON, catodo_ON, dp
  );

  modport slave (
    input  value_in, signed_mode, load,
    output busy, ovf, anode_ON, catodo_ON, dp
  );
endinterface

// File: rtl/bcd_scan_display_conv.sv
// rtl/bcd_scan_display_conv.sv - iterative double-dabble, one bit per cycle
// The first shift happens on the start edge, so done pulses DATA_W-1 cycles later.
module bcd_seq_converter #(
  parameter int DATA_W = 16,
  parameter int NBCD   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] bin_i,
  output logic              done_o,
  output logic [4*NBCD-1:0] bcd_o
);
  localparam int BCD_W = 4 * NBCD;
  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sh_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  adj_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;

  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
      bcd_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        busy_q <= 1'b1;
        cnt_q  <= CNT_W'(1);
        sh_q   <= bin_i << 1;
        bcd_q  <= BCD_W'(bin_i[DATA_W-1]);
      end else if (busy_q) begin
        bcd_q <= {adj_d[BCD_W-2:0], sh_q[DATA_W-1]};
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - binary to multiplexed 7-segment display with sign and overflow
// Capture/sign, atomic glyph commit, digit scan and segment decode.
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DIGITS     = 5,
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic             clk,
  input  logic             rst,
  bcd_scan_display_if.slave bus
);
  localparam int NBCD     = nbcd(DATA_W);
  localparam int SCAN_DIV = CLK_HZ / REFRESH_HZ;
  localparam int PRE_W    = $clog2(SCAN_DIV);
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PADN     = (NBCD > DIGITS) ? NBCD : DIGITS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              neg_q;
  logic              start;
  logic              neg_in;
  logic [DATA_W-1:0] mag_in;
  logic              conv_done;
  logic [4*NBCD-1:0] conv_bcd;
  logic [4*PADN-1:0] bcd_pad;
  int                top_k;
  glyph_e            glyph_q [DIGITS];
  glyph_e            glyph_d [DIGITS];
  logic              ovf_q, ovf_d;
  logic [PRE_W-1:0]  pre_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [6:0]        cat_q;

  assign start  = (state_q == S_IDLE) && bus.load;
  assign neg_in = bus.signed_mode & bus.value_in[DATA_W-1];
  // Negating the most negative value wraps to 2^(DATA_W-1), which is the exact magnitude unsigned.
  assign mag_in = neg_in ? -bus.value_in : bus.value_in;

  bcd_seq_converter #(
    .DATA_W (DATA_W),
    .NBCD   (NBCD)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (mag_in),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.load) state_d = S_CONV;
      S_CONV:   if (conv_done) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bcd_pad              = '0;
    bcd_pad[4*NBCD-1:0]  = conv_bcd;
    top_k                = 0;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_pad[4*i +: 4] != 4'd0) top_k = i;
    end
    ovf_d   = (top_k + 1 + int'(neg_q)) > DIGITS;
    glyph_d = '{default: G_BLANK};
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_d)                           glyph_d[i] = G_MINUS;
      else if (i <= top_k)                 glyph_d[i] = glyph_e'(bcd_pad[4*i +: 4]);
      else if (neg_q && (i == top_k + 1))  glyph_d[i] = G_MINUS;
      else                                 glyph_d[i] = G_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) glyph_q[i] <= G_BLANK;
    end else begin
      state_q <= state_d;
      if (start) neg_q <= neg_in;
      if (state_q == S_COMMIT) begin
        ovf_q   <= ovf_d;
        glyph_q <= glyph_d;
      end
    end
  end

  always_comb begin
    anode_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) anode_d[i] = 1'b0;
    end
  end

  // Anode and cathode are registered on the same edge so a digit never shows its neighbour's segments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      idx_q   <= '0;
      anode_q <= '1;
      cat_q   <= SEG_BLANK;
    end else begin
      if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
        pre_q <= '0;
        idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      anode_q <= anode_d;
      cat_q   <= seg_of(glyph_q[idx_q]);
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ovf       = ovf_q;
  assign bus.anode_ON  = anode_q;
  assign bus.catodo_ON = cat_q;
  assign bus.dp        = 1'b1;
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - table-driven bench over three display configurations
module tb_bcd_scan_display;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] val [3];
  logic        sm  [3];
  logic        ld  [3];
  int n_chk  = 0;
  int n_fail = 0;

  bcd_scan_display_if #(.DATA_W(8),  .DIGITS(4)) if0 ();
  bcd_scan_display_if #(.DATA_W(16), .DIGITS(4)) if1 ();
  bcd_scan_display_if #(.DATA_W(16), .DIGITS(5)) if2 ();

  assign if0.value_in = val[0][7:0];
  assign if0.signed_mode = sm[0];
  assign if0.load = ld[0];
  assign if1.value_in = val[1];
  assign if1.signed_mode = sm[1];
  assign if1.load = ld[1];
  assign if2.value_in = val[2];
  assign if2.signed_mode = sm[2];
  assign if2.load = ld[2];

  bcd_scan_display #(.DATA_W(8), .DIGITS(4), .CLK_HZ(4000), .REFRESH_HZ(1000))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  bcd_scan_display #(.DATA_W(16), .DIGITS(4), .CLK_HZ(4000), .REFRESH_HZ(1000))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  bcd_scan_display #(.DATA_W(16), .DIGITS(5), .CLK_HZ(4000), .REFRESH_HZ(1000))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] MI = 7'h3F;

  function automatic logic [6:0] sd(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return BL;
    endcase
  endfunction

  function automatic logic [55:0] mk(input logic [6:0] d4, d3, d2, d1, d0);
    return {BL, BL, BL, d4, d3, d2, d1, d0};
  endfunction

  function automatic logic [7:0] an_of(input int n);
    case (n)
      0:       return {4'hF, if0.anode_ON};
      1:       return {4'hF, if1.anode_ON};
      default: return {3'h7, if2.anode_ON};
    endcase
  endfunction

  function automatic logic [6:0] cat_of(input int n);
    case (n)
      0:       return if0.catodo_ON;
      1:       return if1.catodo_ON;
      default: return if2.catodo_ON;
    endcase
  endfunction

  function automatic logic busy_of(input int n);
    case (n)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic ovf_of(input int n);
    case (n)
      0:       return if0.ovf;
      1:       return if1.ovf;
      default: return if2.ovf;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_and_wait(input int n, input logic [15:0] v, input logic s, output int cyc);
    @(negedge clk);
    val[n] = v;
    sm[n]  = s;
    ld[n]  = 1'b1;
    @(negedge clk);
    ld[n] = 1'b0;
    cyc = 0;
    while (busy_of(n) && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic read_image(input int n, output logic [55:0] img, output int bad);
    logic [7:0] a;
    logic [7:0] seen;
    logic [7:0] mask;
    mask = (n == 2) ? 8'h1F : 8'h0F;
    img  = {8{BL}};
    seen = '0;
    bad  = 0;
    for (int c = 0; c < 80 && seen != mask; c++) begin
      @(negedge clk);
      a = an_of(n);
      if ($countones(~a) != 1) bad++;
      else begin
        for (int i = 0; i < 8; i++) begin
          if (!a[i]) begin
            img[7*i +: 7] = cat_of(n);
            seen[i] = 1'b1;
          end
        end
      end
    end
    if (seen != mask) bad++;
  endtask

  typedef struct {
    int          n;
    logic [15:0] v;
    logic        s;
    int          cyc;
    logic        ovf;
    logic [55:0] img;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [55:0] img;
    logic [55:0] prev_img;
    logic [7:0]  a;
    int bad, cyc, prev, idx, run, wraps, badt;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      val[i] = '0;
      sm[i]  = 1'b0;
      ld[i]  = 1'b0;
    end

    vecs[0]  = '{0, 16'd255,   1'b0, 9,  1'b0, mk(BL, BL, sd(2), sd(5), sd(5))};
    vecs[1]  = '{0, 16'h0080,  1'b1, 9,  1'b0, mk(BL, MI, sd(1), sd(2), sd(8))};
    vecs[2]  = '{0, 16'h0000,  1'b1, 9,  1'b0, mk(BL, BL, BL, BL, sd(0))};
    vecs[3]  = '{0, 16'h00FF,  1'b1, 9,  1'b0, mk(BL, BL, BL, MI, sd(1))};
    vecs[4]  = '{0, 16'h009C,  1'b1, 9,  1'b0, mk(BL, MI, sd(1), sd(0), sd(0))};
    vecs[5]  = '{0, 16'h009C,  1'b0, 9,  1'b0, mk(BL, BL, sd(1), sd(5), sd(6))};
    vecs[6]  = '{1, 16'd12345, 1'b0, 17, 1'b1, mk(BL, MI, MI, MI, MI)};
    vecs[7]  = '{1, 16'd7,     1'b0, 17, 1'b0, mk(BL, BL, BL, BL, sd(7))};
    vecs[8]  = '{1, 16'd9999,  1'b0, 17, 1'b0, mk(BL, sd(9), sd(9), sd(9), sd(9))};
    vecs[9]  = '{1, 16'hFC18,  1'b1, 17, 1'b1, mk(BL, MI, MI, MI, MI)};
    vecs[10] = '{2, 16'h8000,  1'b0, 17, 1'b0, mk(sd(3), sd(2), sd(7), sd(6), sd(8))};
    vecs[11] = '{2, 16'hFFFF,  1'b1, 17, 1'b0, mk(BL, BL, BL, MI, sd(1))};
    vecs[12] = '{2, 16'd12345, 1'b0, 17, 1'b0, mk(sd(1), sd(2), sd(3), sd(4), sd(5))};
    vecs[13] = '{2, 16'h8000,  1'b1, 17, 1'b1, mk(MI, MI, MI, MI, MI)};

    repeat (3) @(negedge clk);
    check("reset_anode", an_of(2), 8'hFF);
    check("reset_cathode", cat_of(2), BL);
    check("reset_busy", busy_of(2), 1'b0);
    check("reset_ovf", ovf_of(2), 1'b0);
    check("dp_off", if2.dp, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Scan order and dwell on the 5-digit instance.
    prev = -1; run = 0; wraps = 0; badt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      a = an_of(2);
      idx = -1;
      for (int i = 0; i < 5; i++) if (!a[i]) idx = i;
      if ($countones(~a) != 1) badt++;
      else if (prev >= 0 && idx != prev) begin
        if (idx != (prev + 1) % 5) badt++;
        if (prev == 4 && idx == 0) wraps++;
        if (run != 4 && c > 8) badt++;
        run = 0;
      end
      run++;
      prev = idx;
    end
    check("scan_onehot_order_dwell", badt, 0);
    check("scan_wrap_4_to_0", wraps >= 2, 1'b1);

    for (int k = 0; k < 14; k++) begin
      load_and_wait(vecs[k].n, vecs[k].v, vecs[k].s, cyc);
      check($sformatf("v%0d_busy_cycles", k), cyc, vecs[k].cyc);
      @(negedge clk);
      read_image(vecs[k].n, img, bad);
      check($sformatf("v%0d_scan", k), bad, 0);
      check($sformatf("v%0d_ovf", k), ovf_of(vecs[k].n), vecs[k].ovf);
      check($sformatf("v%0d_image", k), img, vecs[k].img);
    end

    // Load 42, then a load of 99 while busy must be dropped with no partial image shown.
    prev_img = vecs[9].img;
    @(negedge clk);
    val[1] = 16'd42;
    sm[1]  = 1'b0;
    ld[1]  = 1'b1;
    @(negedge clk);
    ld[1] = 1'b0;
    cyc = 0;
    bad = 0;
    while (busy_of(1) && cyc < 100) begin
      cyc++;
      ld[1] = (cyc == 3);
      if (cyc == 3) val[1] = 16'd99;
      a = an_of(1);
      for (int i = 0; i < 4; i++) if (!a[i] && cat_of(1) !== prev_img[7*i +: 7]) bad++;
      @(negedge clk);
    end
    ld[1] = 1'b0;
    check("busy_while_42", cyc, 17);
    check("no_partial_image", bad, 0);
    badt = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy_of(1)) badt++;
    end
    check("load_99_dropped", badt, 0);
    read_image(1, img, bad);
    check("img42_scan", bad, 0);
    check("img42", img, mk(BL, BL, BL, sd(4), sd(2)));

    // Reset in the middle of a conversion; the overflow image must not survive.
    @(negedge clk);
    val[2] = 16'd7;
    sm[2]  = 1'b0;
    ld[2]  = 1'b1;
    @(negedge clk);
    ld[2] = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_rst", busy_of(2), 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_anode", an_of(2), 8'hFF);
    check("rst_mid_cathode", cat_of(2), BL);
    check("rst_mid_busy", busy_of(2), 1'b0);
    check("rst_mid_ovf", ovf_of(2), 1'b0);
    @(negedge clk);
    ld[2] = 1'b1;
    @(negedge clk);
    ld[2] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("load_with_rst_ignored", busy_of(2), 1'b0);
    read_image(2, img, bad);
    check("post_rst_scan", bad, 0);
    check("post_rst_blank", img, mk(BL, BL, BL, BL, BL));
    check("post_rst_ovf", ovf_of(2), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
